// File: rtl/dmem_resp_model_if.sv
// Core-side data-memory port bundle: request fields driven by the core,
// response fields driven by the memory responder.
interface dmem_resp_model_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 11
);
  logic [31:0]         addr;
  logic [DATA_W-1:0]   data_wr;
  logic                rd;
  logic [DATA_W/8-1:0] wr;
  logic                cacheable;
  logic [TAG_W-1:0]    req_tag;
  logic                invalidate;
  logic                writeback;
  logic                flush;
  logic                accept;
  logic                ack;
  logic                error;
  logic [DATA_W-1:0]   data_rd;
  logic [TAG_W-1:0]    resp_tag;

  modport master (
    output addr, data_wr, rd, wr, cacheable, req_tag, invalidate, writeback, flush,
    input  accept, ack, error, data_rd, resp_tag
  );

  modport slave (
    input  addr, data_wr, rd, wr, cacheable, req_tag, invalidate, writeback, flush,
    output accept, ack, error, data_rd, resp_tag
  );
endinterface

// File: rtl/dmem_resp_model.sv
// Data-memory responder: accepts requests into a bounded in-order queue,
// resolves reads/writes against a backing array at the accept edge and
// returns each response exactly LATENCY cycles after it was accepted.
module dmem_resp_model #(
  parameter int          DATA_W      = 32,
  parameter int          TAG_W       = 11,
  parameter int          MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          LATENCY     = 2,
  parameter int          OUTSTANDING = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_inj,
  input  logic             err_inj,
  dmem_resp_model_if.slave mem_d
);
  localparam int          BYTES  = DATA_W / 8;
  localparam int          OFF_SH = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int          IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int          CNT_W  = $clog2(OUTSTANDING + 1);
  localparam int          PTR_W  = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  // One spare bit beyond the largest age kept in the queue keeps the
  // modulo age compare unambiguous across counter wrap.
  localparam int          TS_W   = $clog2(LATENCY + 1) + 1;
  localparam logic [32:0] SPAN   = 33'(MEM_WORDS) * 33'(BYTES);

  // Backing array, never reset
  logic [DATA_W-1:0] mem [MEM_WORDS];

  // Queue payload
  logic [TAG_W-1:0]  q_tag  [OUTSTANDING];
  logic [DATA_W-1:0] q_data [OUTSTANDING];
  logic              q_err  [OUTSTANDING];
  logic [TS_W-1:0]   q_ts   [OUTSTANDING];

  // Queue control and cycle counter
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count;
  logic [TS_W-1:0]   cyc;

  // Registered response
  logic              ack_q, err_q;
  logic [DATA_W-1:0] data_q;
  logic [TAG_W-1:0]  tag_q;

  // Request decode
  logic              maint, present, accept, take;
  logic              in_range, misaligned, bad;
  logic              do_write;
  logic [32:0]       off;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_data;
  logic              due;

  assign maint   = mem_d.invalidate | mem_d.writeback | mem_d.flush;
  assign present = mem_d.rd | (|mem_d.wr) | maint;

  // Accept looks only at the registered count: a full queue stays closed
  // even in the cycle its head is being acked.
  assign accept  = rst & ~stall_inj & (count < CNT_W'(OUTSTANDING));
  assign take    = present & accept;

  // Offset is computed one bit wider so an address below BASE_ADDR wraps to
  // a value >= 2^32 and fails the single range compare.
  assign off        = {1'b0, mem_d.addr} - {1'b0, BASE_ADDR};
  assign in_range   = off < SPAN;
  assign misaligned = (mem_d.addr & 32'(BYTES - 1)) != 32'd0;
  assign idx        = IDX_W'(off >> OFF_SH);

  assign bad      = (mem_d.rd & (|mem_d.wr)) | ~in_range | misaligned | err_inj;
  assign do_write = take & ~bad & ~maint & ~mem_d.rd & (|mem_d.wr);
  assign rd_data  = (~bad & ~maint & mem_d.rd) ? mem[idx] : '0;

  // Head is due once its age reaches LATENCY; ages never exceed that since
  // every entry leaves at exactly that age.
  assign due = (count != '0) && ((cyc - q_ts[head]) == TS_W'(LATENCY));

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Capture accepted requests and apply in-range writes per byte lane
  always_ff @(posedge clk) begin
    if (take) begin
      q_tag[tail]  <= mem_d.req_tag;
      q_data[tail] <= rd_data;
      q_err[tail]  <= bad;
      q_ts[tail]   <= cyc;
    end
    if (do_write) begin
      for (int b = 0; b < BYTES; b++) begin
        if (mem_d.wr[b]) mem[idx][b*8 +: 8] <= mem_d.data_wr[b*8 +: 8];
      end
    end
  end

  // Queue pointers, occupancy, cycle counter and response registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      cyc    <= '0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      data_q <= '0;
      tag_q  <= '0;
    end else begin
      cyc   <= cyc + 1'b1;
      ack_q <= due;
      err_q <= due & q_err[head];
      if (due) begin
        data_q <= q_data[head];
        tag_q  <= q_tag[head];
        head   <= nxt(head);
      end
      if (take) tail <= nxt(tail);
      count <= count + CNT_W'(take) - CNT_W'(due);
    end
  end

  assign mem_d.accept   = accept;
  assign mem_d.ack      = ack_q;
  assign mem_d.error    = err_q;
  assign mem_d.data_rd  = data_q;
  assign mem_d.resp_tag = tag_q;

  // Cacheable hint is deliberately ignored; upper offset bits only feed the range check
  logic unused;
  assign unused = ^{mem_d.cacheable, off};
endmodule
